// File: rtl/rom_dump_sequencer_pkg.sv
// Shared constants for the 556PT5/556PT4 PROM dump sequencer: chip geometries,
// operation pin codes and sequencer state encodings.
package rom_dump_sequencer_pkg;

   localparam int IP3604_DATA_WIDTH    = 8;
   localparam int IP3604_ADDRESS_WIDTH = 9;
   localparam int IP3601_DATA_WIDTH    = 4;
   localparam int IP3601_ADDRESS_WIDTH = 8;

   localparam int SETTLE_WIDTH = 8;

   // Operation pins V1..V4, bit0 = V1
   localparam logic [3:0] OP_IDLE = 4'b0000;
   localparam logic [3:0] OP_READ = 4'b1100;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETUP   = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_SEND    = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // The timer flags terminal on zero, so a hold of N cycles loads N-1.
   function automatic logic [SETTLE_WIDTH-1:0] settle_load_value(input int cycles);
      return SETTLE_WIDTH'(cycles - 1);
   endfunction

endpackage

// File: rtl/rom_dump_sequencer_settle_timer.sv
// 8-bit load/count-down timer with a terminal flag, used to hold the PROM
// address stable for the programmed access time before sampling.
module rom_dump_sequencer_settle_timer
   import rom_dump_sequencer_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_load,
   input  logic [SETTLE_WIDTH-1:0] i_load_value,
   input  logic                    i_count,
   output logic                    o_terminal
);

   logic [SETTLE_WIDTH-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_count && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_terminal = (r_count == '0);

endmodule

// File: rtl/rom_dump_sequencer.sv
// Autonomous PROM read sequencer: walks an address range, waits the access
// time, samples the chip and streams {address, data} words over valid/ready.
module rom_dump_sequencer
   import rom_dump_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH    = IP3604_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = IP3604_ADDRESS_WIDTH,
   parameter int SETTLE_CYCLES = 16
)(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_abort,
   input  logic [ADDRESS_WIDTH-1:0] i_first_address,
   input  logic [ADDRESS_WIDTH-1:0] i_last_address,
   input  logic [DATA_WIDTH-1:0]    i_data_line,
   output logic [3:0]               o_operation,
   output logic [ADDRESS_WIDTH-1:0] o_address_line,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [ADDRESS_WIDTH-1:0] o_out_address,
   output logic [DATA_WIDTH-1:0]    o_out_data,
   output logic                     o_busy,
   output logic                     o_done
);

   localparam logic [SETTLE_WIDTH-1:0] LP_SETTLE_LOAD = settle_load_value(SETTLE_CYCLES);

   logic [2:0]               r_state;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [ADDRESS_WIDTH-1:0] r_last;
   logic [ADDRESS_WIDTH-1:0] r_out_address;
   logic [DATA_WIDTH-1:0]    r_out_data;

   logic w_start_ok;
   logic w_last_word;
   logic w_handshake;
   logic w_timer_load;
   logic w_timer_terminal;

   assign w_start_ok  = (r_state == ST_IDLE) && i_start && !i_abort;
   assign w_last_word = (r_addr == r_last);
   assign w_handshake = (r_state == ST_SEND) && i_out_ready;

   // Re-arm the settle hold whenever the next state will be SETUP.
   assign w_timer_load = w_start_ok || (w_handshake && !w_last_word);

   rom_dump_sequencer_settle_timer u_settle_timer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_load       (w_timer_load),
      .i_load_value (LP_SETTLE_LOAD),
      .i_count      (r_state == ST_SETUP),
      .o_terminal   (w_timer_terminal)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_addr        <= '0;
         r_last        <= '0;
         r_out_address <= '0;
         r_out_data    <= '0;
      end else if (i_abort && (r_state != ST_IDLE)) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_ok) begin
                  r_addr  <= i_first_address;
                  r_last  <= i_last_address;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_timer_terminal) r_state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               r_out_address <= r_addr;
               r_out_data    <= i_data_line;
               r_state       <= ST_SEND;
            end
            ST_SEND: begin
               // End detection compares addresses only, so wrapped ranges work.
               if (i_out_ready) begin
                  if (w_last_word) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_addr  <= r_addr + 1'b1;
                     r_state <= ST_SETUP;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_operation = ((r_state == ST_SETUP) || (r_state == ST_CAPTURE) ||
                         (r_state == ST_SEND)) ? OP_READ : OP_IDLE;
   assign o_address_line = r_addr;
   assign o_out_valid    = (r_state == ST_SEND);
   assign o_out_address  = r_out_address;
   assign o_out_data     = r_out_data;
   assign o_busy         = (r_state != ST_IDLE);
   assign o_done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Directed self-checking bench for rom_dump_sequencer (3604 geometry, settle = 4)
// with a chip model that returns the inverted low address byte.
module tb_rom_dump_sequencer;

   logic       clk;
   logic       rstN;
   logic       start;
   logic       abort;
   logic [8:0] firstAddress;
   logic [8:0] lastAddress;
   logic [7:0] dataLine;
   logic [3:0] operation;
   logic [8:0] addressLine;
   logic       outValid;
   logic       outReady;
   logic [8:0] outAddress;
   logic [7:0] outData;
   logic       busy;
   logic       done;

   int testCount = 0;
   int failCount = 0;

   rom_dump_sequencer #(
      .DATA_WIDTH    (8),
      .ADDRESS_WIDTH (9),
      .SETTLE_CYCLES (4)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rstN),
      .i_start         (start),
      .i_abort         (abort),
      .i_first_address (firstAddress),
      .i_last_address  (lastAddress),
      .i_data_line     (dataLine),
      .o_operation     (operation),
      .o_address_line  (addressLine),
      .o_out_valid     (outValid),
      .i_out_ready     (outReady),
      .o_out_address   (outAddress),
      .o_out_data      (outData),
      .o_busy          (busy),
      .o_done          (done)
   );

   // Chip model: data pins show the inverted low byte of the address pins.
   assign dataLine = ~addressLine[7:0];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison goes through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just past the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle with the given range; returns after the accepting edge.
   task automatic applyStimulus(input logic [8:0] first, input logic [8:0] last);
      firstAddress = first;
      lastAddress  = last;
      start        = 1'b1;
      tick();
      start        = 1'b0;
   endtask

   // Wait (bounded) for out_valid; cycles counts the edges spent waiting.
   task automatic waitValid(output int cycles);
      cycles = 0;
      while (!outValid && cycles < 200) begin
         tick();
         cycles++;
      end
      if (!outValid) checkOutput("valid_timeout", 32'(outValid), 32'd1);
   endtask

   // Check the word currently offered on the stream.
   task automatic checkWord(input string tag, input logic [8:0] expAddr,
                            input logic [7:0] expData);
      checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, "_addr"},  32'(outAddress), 32'(expAddr));
      checkOutput({tag, "_data"},  32'(outData), 32'(expData));
      checkOutput({tag, "_op"},    32'(operation), 32'hC);
   endtask

   logic [8:0] t2Addr [4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
   logic [7:0] t2Data [4] = '{8'h01, 8'h00, 8'hFF, 8'hFE};
   logic [7:0] t1Data [4] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};

   initial begin
      int cyc;
      rstN         = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      firstAddress = '0;
      lastAddress  = '0;
      outReady     = 1'b1;

      repeat (3) tick();
      checkOutput("rst_op",    32'(operation), 32'h0);
      checkOutput("rst_addr",  32'(addressLine), 32'h0);
      checkOutput("rst_valid", 32'(outValid), 32'h0);
      checkOutput("rst_oaddr", 32'(outAddress), 32'h0);
      checkOutput("rst_odata", 32'(outData), 32'h0);
      checkOutput("rst_busy",  32'(busy), 32'h0);
      checkOutput("rst_done",  32'(done), 32'h0);
      rstN = 1'b1;
      tick();

      // Test 1: 0..3, ready high, 6-cycle cadence
      applyStimulus(9'h000, 9'h003);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      checkOutput("t1_setup_op", 32'(operation), 32'hC);
      waitValid(cyc);
      checkOutput("t1_latency", 32'(cyc + 1), 32'd6);
      checkWord("t1_w0", 9'h000, t1Data[0]);
      for (int w = 1; w < 4; w++) begin
         tick();
         waitValid(cyc);
         checkOutput("t1_period", 32'(cyc + 1), 32'd6);
         checkWord("t1_w", 9'(w), t1Data[w]);
      end
      tick();
      checkOutput("t1_done", 32'(done), 32'd1);
      checkOutput("t1_done_valid", 32'(outValid), 32'd0);
      checkOutput("t1_done_op", 32'(operation), 32'h0);
      tick();
      checkOutput("t1_done_pulse", 32'(done), 32'd0);
      checkOutput("t1_idle_busy", 32'(busy), 32'd0);

      // Test 2: wrapped range 1FE..001
      applyStimulus(9'h1FE, 9'h001);
      for (int w = 0; w < 4; w++) begin
         if (w != 0) tick();
         waitValid(cyc);
         checkWord("t2_w", t2Addr[w], t2Data[w]);
      end
      tick();
      checkOutput("t2_done", 32'(done), 32'd1);
      tick();

      // Test 3: single word at 0A5
      applyStimulus(9'h0A5, 9'h0A5);
      waitValid(cyc);
      checkWord("t3_w", 9'h0A5, 8'h5A);
      tick();
      checkOutput("t3_done", 32'(done), 32'd1);
      checkOutput("t3_done_busy", 32'(busy), 32'd1);
      tick();
      checkOutput("t3_after_done", 32'(done), 32'd0);
      checkOutput("t3_busy_fall", 32'(busy), 32'd0);

      // Test 4: backpressure for 10 cycles
      outReady = 1'b0;
      applyStimulus(9'h010, 9'h011);
      waitValid(cyc);
      for (int k = 0; k < 10; k++) begin
         tick();
         checkWord("t4_hold", 9'h010, 8'hEF);
         checkOutput("t4_hold_pin", 32'(addressLine), 32'h010);
      end
      outReady = 1'b1;
      tick();
      checkOutput("t4_xfer_valid", 32'(outValid), 32'd0);
      checkOutput("t4_next_pin", 32'(addressLine), 32'h011);
      waitValid(cyc);
      checkWord("t4_w1", 9'h011, 8'hEE);
      tick();
      checkOutput("t4_done", 32'(done), 32'd1);
      tick();

      // Test 5: abort in SETUP of word 2, then restart
      applyStimulus(9'h020, 9'h023);
      waitValid(cyc);
      checkWord("t5_w0", 9'h020, 8'hDF);
      tick();
      checkOutput("t5_setup_pin", 32'(addressLine), 32'h021);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("t5_abort_busy", 32'(busy), 32'd0);
      checkOutput("t5_abort_op", 32'(operation), 32'h0);
      checkOutput("t5_abort_valid", 32'(outValid), 32'd0);
      checkOutput("t5_abort_done", 32'(done), 32'd0);
      tick();
      checkOutput("t5_no_done", 32'(done), 32'd0);
      abort = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checkOutput("t5_start_abort", 32'(busy), 32'd0);
      applyStimulus(9'h020, 9'h023);
      waitValid(cyc);
      checkWord("t5_restart", 9'h020, 8'hDF);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("t5_send_abort_valid", 32'(outValid), 32'd0);
      checkOutput("t5_send_abort_busy", 32'(busy), 32'd0);
      tick();

      // Test 6: start while busy ignored, then async reset mid-SEND
      applyStimulus(9'h030, 9'h032);
      tick();
      firstAddress = 9'h100;
      lastAddress  = 9'h100;
      start        = 1'b1;
      tick();
      start        = 1'b0;
      waitValid(cyc);
      checkWord("t6_w0", 9'h030, 8'hCF);
      outReady = 1'b0;
      tick();
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      waitValid(cyc);
      checkWord("t6_w1", 9'h031, 8'hCE);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("t6_rst_valid", 32'(outValid), 32'd0);
      checkOutput("t6_rst_busy",  32'(busy), 32'd0);
      checkOutput("t6_rst_op",    32'(operation), 32'h0);
      checkOutput("t6_rst_pin",   32'(addressLine), 32'h0);
      checkOutput("t6_rst_oaddr", 32'(outAddress), 32'h0);
      checkOutput("t6_rst_odata", 32'(outData), 32'h0);
      checkOutput("t6_rst_done",  32'(done), 32'h0);
      tick();
      rstN     = 1'b1;
      outReady = 1'b1;
      tick();
      checkOutput("t6_post_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
